// File: rtl/common.sv
// Shared address types used across the memory-side blocks.
package common;
  localparam int PADDR_W = 32;
  typedef logic [PADDR_W-1:0] t_paddr;
endpackage

// File: rtl/ic_rsp_pipe_pkg.sv
// Line geometry helpers for the instruction responder.
package ic_rsp_pipe_pkg;
  import common::*;
  import mem_common::*;

  localparam int WORDS_PER_LINE = CL_BYTES / 4;
  localparam int LINE_SH        = $clog2(CL_BYTES);
  localparam int WORD_SH        = $clog2(WORDS_PER_LINE);

  function automatic t_paddr line_align(t_paddr a);
    return a & ~t_paddr'(CL_BYTES - 1);
  endfunction
endpackage

// File: rtl/mem_common.sv
// Cache-line request/response types for the fetch buffer <-> instruction memory link.
package mem_common;
  import common::*;

  localparam int CL_BYTES = 64;
  localparam int MEM_ID_W = 4;

  typedef logic [CL_BYTES*8-1:0] t_cl;

  typedef struct packed {
    logic                valid;
    logic [MEM_ID_W-1:0] id;
    t_paddr              addr;
  } t_mem_req;

  typedef struct packed {
    logic                valid;
    logic [MEM_ID_W-1:0] id;
    t_paddr              addr;
    t_cl                 data;
    logic                err;
  } t_mem_rsp;
endpackage

// File: rtl/ic_req_q.sv
// In-order request FIFO. A push into a full queue is accepted only when a pop
// frees the head in the same cycle; otherwise it is ignored.
module ic_req_q
  import common::*;
  import mem_common::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  t_mem_req         push_req,
  input  logic             pop,
  output t_mem_req         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  t_mem_req         mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_req;
  end

`ifdef ASSERT
  always_ff @(posedge clk) begin
    if (!reset) assert (!(do_push && full && !do_pop));
  end
`endif

endmodule

// File: rtl/ic_rsp_pipe.sv
// Instruction-side memory responder: queues line reads, reads a word array and
// returns whole lines in order after LATENCY cycles. Loader writes win the array.
module ic_rsp_pipe
  import common::*;
  import mem_common::*;
  import ic_rsp_pipe_pkg::*;
#(
  parameter  int LATENCY    = 2,
  parameter  int QDEPTH     = 4,
  parameter  int IROM_WORDS = 4096,
  localparam int IA_W       = $clog2(IROM_WORDS)
) (
  input  logic            clk,
  input  logic            reset,
  input  t_mem_req        fb_ic_req_nnn,
  output t_mem_rsp        ic_fb_rsp_nnn,
  input  logic            irom_wr_en,
  input  logic [IA_W-1:0] irom_wr_addr,
  input  logic [31:0]     irom_wr_data,
  output logic            ic_busy,
  output logic            ic_ovfl
);

  localparam int IROM_LINES = IROM_WORDS / WORDS_PER_LINE;
  localparam int LIDX_W     = IA_W - WORD_SH;
  localparam int CNT_W      = $clog2(QDEPTH) + 1;

  t_mem_req         head;
  logic             q_full, q_empty;
  logic [CNT_W-1:0] q_count;
  logic             issue;

  logic [31:0]      irom_q [IROM_WORDS];
  t_paddr           line_idx;
  t_cl              rd_data;
  logic             rd_err;

  t_mem_rsp         pipe_q [1:LATENCY];
  t_mem_rsp         pipe_d [1:LATENCY];
  logic             any_vld;
  logic             ovfl_q, ovfl_d;

  ic_req_q #(.DEPTH(QDEPTH)) u_req_q (
    .clk      (clk),
    .reset    (reset),
    .push     (fb_ic_req_nnn.valid),
    .push_req (fb_ic_req_nnn),
    .pop      (issue),
    .head     (head),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  // A loader write owns the single array port for its cycle.
  assign issue = !q_empty && !irom_wr_en;

  always_ff @(posedge clk) begin
    if (irom_wr_en) irom_q[irom_wr_addr] <= irom_wr_data;
  end

  always_comb begin
    line_idx = head.addr >> LINE_SH;
    rd_err   = (line_idx >= t_paddr'(IROM_LINES));
    rd_data  = '0;
    if (!rd_err) begin
      for (int w = 0; w < WORDS_PER_LINE; w++)
        rd_data[w*32 +: 32] = irom_q[{line_idx[LIDX_W-1:0], WORD_SH'(w)}];
    end
  end

  // Idle stages carry all-zero payloads so the response bus reads 0 when not valid.
  always_comb begin
    pipe_d[1] = '0;
    if (issue) begin
      pipe_d[1].valid = 1'b1;
      pipe_d[1].id    = head.id;
      pipe_d[1].addr  = line_align(head.addr);
      pipe_d[1].data  = rd_data;
      pipe_d[1].err   = rd_err;
    end
    for (int s = 2; s <= LATENCY; s++) pipe_d[s] = pipe_q[s-1];
  end

  always_comb begin
    any_vld = 1'b0;
    for (int s = 1; s <= LATENCY; s++) any_vld = any_vld | pipe_q[s].valid;
  end

  assign ovfl_d = ovfl_q | (fb_ic_req_nnn.valid && q_full && !issue);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 1; s <= LATENCY; s++) pipe_q[s] <= '0;
      ovfl_q <= 1'b0;
    end else begin
      for (int s = 1; s <= LATENCY; s++) pipe_q[s] <= pipe_d[s];
      ovfl_q <= ovfl_d;
    end
  end

  assign ic_fb_rsp_nnn = pipe_q[LATENCY];
  assign ic_busy       = (q_count != '0) || any_vld;
  assign ic_ovfl       = ovfl_q;

`ifdef ASSERT
  logic [MEM_ID_W-1:0] exp_id_q [$];
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_id_q.delete();
    end else begin
      if (ic_fb_rsp_nnn.valid) begin
        assert (exp_id_q.size() > 0 && exp_id_q[0] == ic_fb_rsp_nnn.id);
        if (exp_id_q.size() > 0) void'(exp_id_q.pop_front());
      end
      if (fb_ic_req_nnn.valid && (!q_full || issue)) exp_id_q.push_back(fb_ic_req_nnn.id);
    end
  end
`endif

endmodule

// File: tb/tb_ic_rsp_pipe.sv
// Directed bench for ic_rsp_pipe: latency, streaming, write stalls, overflow,
// out-of-range lines, read-after-write and reset while busy.
module tb_ic_rsp_pipe;
  import common::*;
  import mem_common::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  t_mem_req    req;
  t_mem_rsp    rsp;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy, ovfl;
  int          checks = 0;
  int          errors = 0;
  int          n_rsp;

  always #5 clk = ~clk;

  ic_rsp_pipe #(.LATENCY(2), .QDEPTH(4), .IROM_WORDS(4096)) dut (
    .clk           (clk),
    .reset         (reset),
    .fb_ic_req_nnn (req),
    .ic_fb_rsp_nnn (rsp),
    .irom_wr_en    (wr_en),
    .irom_wr_addr  (wr_addr),
    .irom_wr_data  (wr_data),
    .ic_busy       (busy),
    .ic_ovfl       (ovfl)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int id, input logic [31:0] a);
    req.valid = 1'b1;
    req.id    = 4'(id);
    req.addr  = a;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 12'(a);
    wr_data = d;
  endtask

  // Preloaded contents: word k holds k.
  function automatic logic [511:0] ramp(input int base);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = 32'(base + i);
    return v;
  endfunction

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [511:0] exp_line;
    req = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset state
    step();
    chk("rst_valid", rsp.valid, 0);
    chk("rst_id", rsp.id, 0);
    chk("rst_data", rsp.data, '0);
    chk("rst_busy", busy, 0);
    chk("rst_ovfl", ovfl, 0);
    reset = 1'b0;

    for (int k = 0; k < 256; k++) begin
      wr(k, 32'(k));
      step();
    end
    wr_en = 1'b0;
    step();

    // Single request: visible three windows later
    send(3, 32'h40);
    step();
    req = '0;
    chk("single_busy", busy, 1);
    step();
    chk("single_early", rsp.valid, 0);
    step();
    chk("single_valid", rsp.valid, 1);
    chk("single_id", rsp.id, 3);
    chk("single_addr", rsp.addr, 32'h40);
    chk("single_data", rsp.data, ramp(16));
    chk("single_err", rsp.err, 0);
    step();
    chk("single_after", rsp.valid, 0);
    chk("single_idle", busy, 0);

    // Streaming: ids 0..7 back to back
    for (int t = 0; t < 12; t++) begin
      req = '0;
      if (t < 8) send(t, 32'(t * 64));
      step();
      if (t >= 2 && t <= 9) begin
        chk($sformatf("stream_valid%0d", t), rsp.valid, 1);
        chk($sformatf("stream_id%0d", t), rsp.id, 4'(t - 2));
        chk($sformatf("stream_data%0d", t), rsp.data, ramp((t - 2) * 16));
      end else begin
        chk($sformatf("stream_idle%0d", t), rsp.valid, 0);
      end
      if (t == 9)  chk("stream_busy_last", busy, 1);
      if (t == 10) chk("stream_busy_done", busy, 0);
    end
    req = '0;

    // Write contention: two write cycles push both responses out by two
    for (int t = 0; t < 8; t++) begin
      req = '0;
      wr_en = 1'b0;
      if (t == 0) send(1, 32'h80);
      if (t == 1) send(2, 32'hC0);
      if (t == 1 || t == 2) wr(200, 32'd200);
      step();
      if (t == 4) begin
        chk("wc_valid1", rsp.valid, 1);
        chk("wc_id1", rsp.id, 1);
        chk("wc_data1", rsp.data, ramp(32));
      end else if (t == 5) begin
        chk("wc_valid2", rsp.valid, 1);
        chk("wc_id2", rsp.id, 2);
        chk("wc_data2", rsp.data, ramp(48));
      end else begin
        chk($sformatf("wc_idle%0d", t), rsp.valid, 0);
      end
    end
    chk("wc_ovfl", ovfl, 0);

    // Overflow: five pushes while writes hold off issue
    n_rsp = 0;
    for (int t = 0; t < 16; t++) begin
      req = '0;
      wr_en = 1'b0;
      if (t < 5) send(t, 32'(t * 64));
      if (t < 6) wr(200, 32'd200);
      step();
      if (t == 3) chk("ovf_before", ovfl, 0);
      if (t == 4) chk("ovf_set", ovfl, 1);
      if (rsp.valid) n_rsp++;
      if (t >= 7 && t <= 10) chk($sformatf("ovf_id%0d", t), rsp.id, 4'(t - 7));
    end
    chk("ovf_nrsp", n_rsp, 4);
    chk("ovf_sticky", ovfl, 1);

    // Full queue plus pop in the same cycle accepts the push
    do_reset();
    chk("reset_clears_ovfl", ovfl, 0);
    n_rsp = 0;
    for (int t = 0; t < 12; t++) begin
      req = '0;
      wr_en = 1'b0;
      if (t < 5) send(t, 32'(t * 64));
      if (t < 4) wr(200, 32'd200);
      step();
      if (rsp.valid) n_rsp++;
      if (t >= 5 && t <= 9) chk($sformatf("pwf_id%0d", t), rsp.id, 4'(t - 5));
    end
    chk("pwf_nrsp", n_rsp, 5);
    chk("pwf_ovfl", ovfl, 0);

    // Out-of-range line
    req = '0; wr_en = 1'b0;
    send(5, 32'(4096 * 4));
    step();
    req = '0;
    step();
    step();
    chk("oor_valid", rsp.valid, 1);
    chk("oor_err", rsp.err, 1);
    chk("oor_data", rsp.data, '0);
    chk("oor_addr", rsp.addr, 32'h4000);

    // Read-after-write, unaligned address aligns down to line 0
    wr(5, 32'hDEADBEEF);
    step();
    wr_en = 1'b0;
    send(6, 32'h3C);
    step();
    req = '0;
    step();
    step();
    exp_line = ramp(0);
    exp_line[5*32 +: 32] = 32'hDEADBEEF;
    chk("raw_valid", rsp.valid, 1);
    chk("raw_id", rsp.id, 6);
    chk("raw_addr", rsp.addr, 32'h0);
    chk("raw_data", rsp.data, exp_line);
    step();

    // Reset with three requests queued
    for (int t = 0; t < 3; t++) begin
      send(t + 8, 32'(t * 64));
      wr(200, 32'd200);
      step();
    end
    req = '0;
    chk("mid_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_valid", rsp.valid, 0);
    chk("mid_busy", busy, 0);
    step();
    reset = 1'b0;
    wr_en = 1'b0;
    n_rsp = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (rsp.valid) n_rsp++;
    end
    chk("mid_stale", n_rsp, 0);
    chk("mid_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
